avg_pool_unit: RTL and testbench



---
 rtl/avg_pool_pkg.sv | 14 +
 rtl/avg_pool_unit.sv | 66 ++++++
 tb/tb_avg_pool_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/avg_pool_pkg.sv
// Shared sizing constants for the streaming average-pooling unit.
// The accumulator carries one guard bit beyond DATA_W+WIN_LOG2 so the rounding bias never overflows.
package avg_pool_pkg;

    localparam int AVG_DATA_W   = 32;
    localparam int AVG_WIN_LOG2 = 2;
    localparam int AVG_ACC_W    = AVG_DATA_W + AVG_WIN_LOG2 + 1;
    localparam int AVG_CNT_W    = AVG_WIN_LOG2;

    function automatic int acc_width(input int data_w, input int win_log2);
        return data_w + win_log2 + 1;
    endfunction

endpackage

// File: rtl/avg_pool_unit.sv
// Streaming window mean: accumulates 2^WIN_LOG2 signed samples and registers their mean on avg.
// Build option AVG_POOL_ROUND_EN: round-half-up with positive saturation instead of floor.
module avg_pool_unit
    import avg_pool_pkg::*;
#(
    parameter int DATA_W   = AVG_DATA_W,
    parameter int WIN_LOG2 = AVG_WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] layer2,
    output logic signed [DATA_W-1:0] avg
);

    localparam int ACC_W = acc_width(DATA_W, WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

`ifdef AVG_POOL_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) <<< (WIN_LOG2 - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
`endif

    logic signed [ACC_W-1:0]  acc;
    logic [WIN_LOG2-1:0]      cnt;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;

    // Floor can never leave the DATA_W range; rounding can only overshoot the top.
    function automatic logic signed [DATA_W-1:0] finalize(input logic signed [ACC_W-1:0] s);
`ifdef AVG_POOL_ROUND_EN
        logic signed [ACC_W-1:0] r;
        r = (s + ROUND_BIAS) >>> WIN_LOG2;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end
        return DATA_W'(r);
`else
        return DATA_W'(s >>> WIN_LOG2);
`endif
    endfunction

    always_comb begin
        sample_ext = {{(ACC_W - DATA_W){layer2[DATA_W-1]}}, layer2};
        sum        = acc + sample_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            avg <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                avg <= finalize(sum);
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_pool_unit.sv
// Directed bench for avg_pool_unit with a reference model and an expected-result queue.
// Honours AVG_POOL_ROUND_EN so the same bench checks either build.
module tb_avg_pool_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic signed [31:0] layer2;
    logic signed [31:0] avg;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [31:0] sb[$];
    longint             m_acc;
    int                 m_cnt;
    logic signed [31:0] m_avg;

    always #5 clk = ~clk;

    avg_pool_unit dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .layer2 (layer2),
        .avg    (avg)
    );

    function automatic logic signed [31:0] model_final(input longint s);
        longint r;
`ifdef AVG_POOL_ROUND_EN
        r = (s + 2) >>> 2;
        if (r > 64'sh7FFFFFFF) r = 64'sh7FFFFFFF;
`else
        r = s >>> 2;
`endif
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check 1 time unit later.
    task automatic cyc(input logic r, input logic e, input logic signed [31:0] d);
        rst    = r;
        enable = e;
        layer2 = d;
        @(posedge clk);
        if (r) begin
            m_acc = 0;
            m_cnt = 0;
            m_avg = 0;
            sb.push_back(32'sd0);
        end else if (e) begin
            m_acc += longint'(d);
            if (m_cnt == 3) begin
                m_avg = model_final(m_acc);
                sb.push_back(m_avg);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
        if (sb.size() > 0) check("window", avg, sb.pop_front());
        else               check("hold", avg, m_avg);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; layer2 = '0;
        m_acc = 0; m_cnt = 0; m_avg = 0;

        cyc(1, 0, 0);
        cyc(1, 1, 55);
        check("reset", avg, 0);

        cyc(0, 1, 10); cyc(0, 1, 20); cyc(0, 1, 30);
        check("pre_final", avg, 0);
        cyc(0, 1, 40);
        check("mean_25", avg, 25);
        for (int i = 0; i < 5; i++) cyc(0, 0, 32'sd777);
        check("hold_25", avg, 25);

        cyc(0, 1, -1); cyc(0, 1, -2); cyc(0, 1, -2); cyc(0, 1, -2);
        check("sum_m7", avg, -2);

        cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 0);
`ifdef AVG_POOL_ROUND_EN
        check("sum_3", avg, 1);
`else
        check("sum_3", avg, 0);
`endif

        for (int i = 0; i < 4; i++) cyc(0, 1, 32'sh7FFFFFFF);
        check("max_pos", avg, 32'sh7FFFFFFF);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'sh80000000);
        check("max_neg", avg, 32'sh80000000);

        cyc(0, 1, 5); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 7); cyc(0, 0, 0); cyc(0, 1, 9);
        check("gap_prev", avg, 32'sh80000000);
        cyc(0, 1, 11);
        check("gap_8", avg, 8);

        for (int i = 0; i < 4; i++) cyc(0, 1, 4);
        check("b2b_4", avg, 4);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8);
        check("b2b_hold4", avg, 4);
        cyc(0, 1, 8);
        check("b2b_8", avg, 8);

        cyc(0, 1, 100); cyc(0, 1, 100);
        cyc(1, 1, 999);
        check("mid_rst", avg, 0);
        cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 3);
        check("post_rst_hold", avg, 0);
        cyc(0, 1, 6);
        check("post_rst_3", avg, 3);

        for (int i = 0; i < 8; i++) cyc(0, 1, $signed($urandom_range(2000, 0)) - 1000);
        cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
